// File: rtl/seven_seg_scan_driver.sv
// Six-digit multiplexed 7-segment driver for the watch display: snapshots time fields once per
// frame, converts them to BCD with one shared double-dabble engine, and scans the digits.
`timescale 1ns/1ps

module seven_seg_scan_driver #(
    parameter int unsigned SCAN_DIV     = 25,
    parameter int unsigned BLINK_FRAMES = 16
) (
    input  logic       Clock_5K,
    input  logic       Reset,
    input  logic       Control,
    input  logic       AM_PM,
    input  logic [3:0] Hours,
    input  logic [5:0] Mins,
    input  logic [5:0] Secs,
    input  logic [9:0] MSecs,
    input  logic       Alarm,
    output logic [6:0] Seg,
    output logic       DP,
    output logic [5:0] Digit_En,
    output logic       Frame_Start
);

    localparam int unsigned SCAN_W  = $clog2(SCAN_DIV);
    localparam int unsigned BLINK_W = $clog2(BLINK_FRAMES + 1);

    typedef enum logic [1:0] {
        CV_IDLE,
        CV_LOAD,
        CV_SHIFT,
        CV_DONE
    } cv_state_t;

    // Scan position
    logic [SCAN_W-1:0] scan_cnt;
    logic [2:0]        idx;
    logic              frame_tick;

    // Frame snapshot of the inputs
    logic       sh_clk;
    logic       sh_pm;
    logic [3:0] sh_hours;
    logic [5:0] sh_mins;
    logic [5:0] sh_secs;
    logic [9:0] sh_msecs;

    // Converter
    cv_state_t       cv_state;
    logic [1:0]      field;
    logic [3:0]      bit_cnt;
    logic [21:0]     dd;
    logic [21:0]     dd_adj;
    logic [21:0]     dd_shift;
    logic [9:0]      field_val;
    logic [3:0]      dig_hi;
    logic [3:0]      dig_lo;
    logic [5:0][3:0] res;

    // Displayed state
    logic [5:0][3:0] shown;
    logic            shown_clk;
    logic            shown_pm;
    logic [3:0]      cur_digit;
    logic            cur_blank;

    // Alarm blink
    logic               blink_en;
    logic               phase_off;
    logic [BLINK_W-1:0] blink_cnt;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign frame_tick = (scan_cnt == '0) && (idx == 3'd0);
    assign blink_en   = Alarm && Control;

    //--------------------------------------------------------------------------
    // Scan counters and frame snapshot
    //--------------------------------------------------------------------------
    always_ff @(posedge Clock_5K) begin
        if (Reset) begin
            scan_cnt <= '0;
            idx      <= 3'd0;
            sh_clk   <= 1'b0;
            sh_pm    <= 1'b0;
            sh_hours <= '0;
            sh_mins  <= '0;
            sh_secs  <= '0;
            sh_msecs <= '0;
        end else begin
            if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                idx      <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end
            if (frame_tick) begin
                sh_clk   <= Control;
                sh_pm    <= AM_PM;
                sh_hours <= Hours;
                sh_mins  <= Mins;
                sh_secs  <= Secs;
                sh_msecs <= MSecs;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Double-dabble datapath: {hundreds, tens, units, binary}
    //--------------------------------------------------------------------------
    always_comb begin
        field_val = '0;
        if (sh_clk) begin
            case (field)
                2'd0:    field_val = {6'd0, sh_hours};
                2'd1:    field_val = {4'd0, sh_mins};
                default: field_val = {4'd0, sh_secs};
            endcase
        end else begin
            case (field)
                2'd0:    field_val = {4'd0, sh_mins};
                2'd1:    field_val = {4'd0, sh_secs};
                default: field_val = sh_msecs;
            endcase
        end
    end

    always_comb begin
        dd_adj = dd;
        for (int unsigned n = 0; n < 3; n++) begin
            if (dd_adj[10 + 4*n +: 4] >= 4'd5) begin
                dd_adj[10 + 4*n +: 4] = dd_adj[10 + 4*n +: 4] + 4'd3;
            end
        end
        dd_shift = dd_adj << 1;
    end

    // Hundredths come from MSecs/10, so that field keeps hundreds and tens
    always_comb begin
        if (!sh_clk && field == 2'd2) begin
            dig_hi = dd_shift[21:18];
            dig_lo = dd_shift[17:14];
        end else begin
            dig_hi = dd_shift[17:14];
            dig_lo = dd_shift[13:10];
        end
    end

    //--------------------------------------------------------------------------
    // Converter FSM: results go to res and reach shown only at DONE
    //--------------------------------------------------------------------------
    always_ff @(posedge Clock_5K) begin
        if (Reset) begin
            cv_state  <= CV_IDLE;
            field     <= 2'd0;
            bit_cnt   <= 4'd0;
            dd        <= '0;
            res       <= '0;
            shown     <= '0;
            shown_clk <= 1'b0;
            shown_pm  <= 1'b0;
        end else begin
            case (cv_state)
                CV_IDLE: begin
                    if (frame_tick) begin
                        field    <= 2'd0;
                        cv_state <= CV_LOAD;
                    end
                end
                CV_LOAD: begin
                    dd       <= {12'd0, field_val};
                    bit_cnt  <= 4'd0;
                    cv_state <= CV_SHIFT;
                end
                CV_SHIFT: begin
                    dd      <= dd_shift;
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd9) begin
                        res[{field, 1'b0}] <= dig_hi;
                        res[{field, 1'b1}] <= dig_lo;
                        if (field == 2'd2) begin
                            cv_state <= CV_DONE;
                        end else begin
                            field    <= field + 2'd1;
                            cv_state <= CV_LOAD;
                        end
                    end
                end
                CV_DONE: begin
                    shown     <= res;
                    shown_clk <= sh_clk;
                    shown_pm  <= sh_pm;
                    cv_state  <= CV_IDLE;
                end
                default: cv_state <= CV_IDLE;
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Alarm blink phase
    //--------------------------------------------------------------------------
    always_ff @(posedge Clock_5K) begin
        if (Reset || !blink_en) begin
            phase_off <= 1'b0;
            blink_cnt <= '0;
        end else if (frame_tick) begin
            if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                phase_off <= ~phase_off;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end
    end

    //--------------------------------------------------------------------------
    // Registered display outputs
    //--------------------------------------------------------------------------
    assign cur_digit = shown[idx];
    assign cur_blank = shown_clk && (idx == 3'd0) && (cur_digit == 4'd0);

    // Live blink_en lets Alarm=0 restore scanning on the very next cycle
    always_ff @(posedge Clock_5K) begin
        if (Reset) begin
            Seg         <= 7'h7F;
            DP          <= 1'b1;
            Digit_En    <= 6'h3F;
            Frame_Start <= 1'b0;
        end else begin
            Seg         <= cur_blank ? 7'h7F : seg_code(cur_digit);
            DP          <= ~((idx == 3'd1) || (idx == 3'd3) ||
                             ((idx == 3'd5) && shown_clk && shown_pm));
            Digit_En    <= ((scan_cnt == '0) || (blink_en && phase_off)) ?
                           6'h3F : ~(6'b100000 >> idx);
            Frame_Start <= frame_tick;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver: reset, clock/stopwatch digits, conversion latency,
// mid-frame input changes, alarm blink and reset during conversion.
`timescale 1ns/1ps

module tb_seven_seg_scan_driver;

    logic       clk;
    logic       Reset;
    logic       Control;
    logic       AM_PM;
    logic [3:0] Hours;
    logic [5:0] Mins;
    logic [5:0] Secs;
    logic [9:0] MSecs;
    logic       Alarm;
    logic [6:0] Seg;
    logic       DP;
    logic [5:0] Digit_En;
    logic       Frame_Start;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [6:0] exp_seg [6];
    logic       exp_dp  [6];

    seven_seg_scan_driver #(
        .SCAN_DIV     (25),
        .BLINK_FRAMES (16)
    ) dut (
        .Clock_5K    (clk),
        .Reset       (Reset),
        .Control     (Control),
        .AM_PM       (AM_PM),
        .Hours       (Hours),
        .Mins        (Mins),
        .Secs        (Secs),
        .MSecs       (MSecs),
        .Alarm       (Alarm),
        .Seg         (Seg),
        .DP          (DP),
        .Digit_En    (Digit_En),
        .Frame_Start (Frame_Start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Leaves the bench on the negedge where Frame_Start is seen (slot position 0)
    task automatic wait_frame(input string tag);
        int unsigned n;
        n = 0;
        @(negedge clk);
        while (Frame_Start !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (Frame_Start !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL %s frame_wait: Frame_Start=%b required 1 within 400 cycles", tag, Frame_Start);
        end
    endtask

    // Walks the six slot centres of the current frame against exp_seg/exp_dp
    task automatic scan_frame(input string tag);
        logic [5:0] one;
        repeat (12) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            one = 6'b100000 >> i;
            total++;
            if (Seg !== exp_seg[i]) begin
                bad++;
                $display("FAIL %s seg idx%0d: got %h required %h", tag, i, Seg, exp_seg[i]);
            end
            total++;
            if (DP !== exp_dp[i]) begin
                bad++;
                $display("FAIL %s dp idx%0d: got %b required %b", tag, i, DP, exp_dp[i]);
            end
            total++;
            if (Digit_En !== ~one) begin
                bad++;
                $display("FAIL %s digit_en idx%0d: got %h required %h", tag, i, Digit_En, ~one);
            end
            if (i < 5) repeat (25) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        total++;
        if (Seg !== 7'h7F) begin bad++; $display("FAIL reset seg: got %h required 7f", Seg); end
        total++;
        if (DP !== 1'b1) begin bad++; $display("FAIL reset dp: got %b required 1", DP); end
        total++;
        if (Digit_En !== 6'h3F) begin bad++; $display("FAIL reset digit_en: got %h required 3f", Digit_En); end
        total++;
        if (Frame_Start !== 1'b0) begin bad++; $display("FAIL reset frame_start: got %b required 0", Frame_Start); end
        Reset = 1'b0;
        @(negedge clk);
        total++;
        if (Frame_Start !== 1'b1) begin bad++; $display("FAIL release frame_start: got %b required 1", Frame_Start); end
        total++;
        if (Digit_En !== 6'h3F) begin bad++; $display("FAIL release gap digit_en: got %h required 3f", Digit_En); end
        @(negedge clk);
        total++;
        if (Digit_En !== 6'h1F) begin bad++; $display("FAIL release idx0 digit_en: got %h required 1f", Digit_En); end
        total++;
        if (Frame_Start !== 1'b0) begin bad++; $display("FAIL release pulse width: got %b required 0", Frame_Start); end
        total++;
        if (Seg !== 7'h40) begin bad++; $display("FAIL release seg: got %h required 40", Seg); end
    endtask

    task automatic test_clock_mode();
        Control = 1'b1; AM_PM = 1'b0; Hours = 4'd1; Mins = 6'd50; Secs = 6'd20; Alarm = 1'b0;
        wait_frame("clock");
        wait_frame("clock");
        exp_seg = '{7'h7F, 7'h79, 7'h12, 7'h40, 7'h24, 7'h40};
        exp_dp  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        scan_frame("clock_1_50_20");
    endtask

    task automatic test_stopwatch();
        Control = 1'b0; Mins = 6'd3; Secs = 6'd7; MSecs = 10'd456;
        wait_frame("stopwatch");
        repeat (34) @(negedge clk);
        total++;
        if (Seg !== 7'h79) begin bad++; $display("FAIL latency old digit: got %h required 79", Seg); end
        @(negedge clk);
        total++;
        if (Seg !== 7'h30) begin bad++; $display("FAIL latency new digit: got %h required 30", Seg); end
        wait_frame("stopwatch");
        exp_seg = '{7'h40, 7'h30, 7'h40, 7'h78, 7'h19, 7'h12};
        exp_dp  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        scan_frame("stopwatch_3_7_456");
    endtask

    task automatic test_midframe_change();
        Control = 1'b1; Hours = 4'd1; Mins = 6'd50; Secs = 6'd20; MSecs = 10'd0;
        wait_frame("midframe");
        wait_frame("midframe");
        repeat (50) @(negedge clk);
        Secs = 6'd21;
        repeat (62) @(negedge clk);
        total++;
        if (Seg !== 7'h24) begin bad++; $display("FAIL midframe idx4 held: got %h required 24", Seg); end
        repeat (25) @(negedge clk);
        total++;
        if (Seg !== 7'h40) begin bad++; $display("FAIL midframe idx5 held: got %h required 40", Seg); end
        wait_frame("midframe");
        repeat (112) @(negedge clk);
        total++;
        if (Seg !== 7'h24) begin bad++; $display("FAIL midframe idx4 new: got %h required 24", Seg); end
        repeat (25) @(negedge clk);
        total++;
        if (Seg !== 7'h79) begin bad++; $display("FAIL midframe idx5 new: got %h required 79", Seg); end
    endtask

    task automatic test_alarm_blink();
        logic [5:0] want;
        Hours = 4'd12; Mins = 6'd0; Secs = 6'd0; AM_PM = 1'b1;
        wait_frame("pm");
        wait_frame("pm");
        repeat (12) @(negedge clk);
        total++;
        if (Seg !== 7'h79) begin bad++; $display("FAIL pm hours tens: got %h required 79", Seg); end
        repeat (25) @(negedge clk);
        total++;
        if (Seg !== 7'h24) begin bad++; $display("FAIL pm hours units: got %h required 24", Seg); end
        repeat (100) @(negedge clk);
        total++;
        if (DP !== 1'b0) begin bad++; $display("FAIL pm dp idx5: got %b required 0", DP); end
        wait_frame("blink");
        Alarm = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            wait_frame("blink");
            repeat (40) @(negedge clk);
            want = (k >= 16) ? 6'h3F : 6'h2F;
            total++;
            if (Digit_En !== want) begin
                bad++;
                $display("FAIL blink frame%0d digit_en: got %h required %h", k, Digit_En, want);
            end
        end
        Alarm = 1'b0;
        @(negedge clk);
        total++;
        if (Digit_En !== 6'h2F) begin bad++; $display("FAIL alarm off digit_en: got %h required 2f", Digit_En); end
    endtask

    task automatic test_reset_mid_conversion();
        Control = 1'b1; AM_PM = 1'b0; Hours = 4'd9; Mins = 6'd34; Secs = 6'd56;
        wait_frame("rst_mid");
        repeat (10) @(negedge clk);
        Reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (Seg !== 7'h7F) begin bad++; $display("FAIL rst_mid seg: got %h required 7f", Seg); end
        total++;
        if (DP !== 1'b1) begin bad++; $display("FAIL rst_mid dp: got %b required 1", DP); end
        total++;
        if (Digit_En !== 6'h3F) begin bad++; $display("FAIL rst_mid digit_en: got %h required 3f", Digit_En); end
        total++;
        if (Frame_Start !== 1'b0) begin bad++; $display("FAIL rst_mid frame_start: got %b required 0", Frame_Start); end
        Reset = 1'b0;
        @(negedge clk);
        total++;
        if (Frame_Start !== 1'b1) begin bad++; $display("FAIL rst_mid restart: got %b required 1", Frame_Start); end
        repeat (11) @(negedge clk);
        total++;
        if (Seg !== 7'h40) begin bad++; $display("FAIL rst_mid idx0 cleared: got %h required 40", Seg); end
        repeat (22) @(negedge clk);
        total++;
        if (Seg !== 7'h40) begin bad++; $display("FAIL rst_mid idx1 cleared: got %h required 40", Seg); end
        wait_frame("rst_mid");
        exp_seg = '{7'h7F, 7'h10, 7'h30, 7'h19, 7'h12, 7'h02};
        exp_dp  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        scan_frame("clock_9_34_56");
    endtask

    initial begin
        Reset = 1'b1; Control = 1'b0; AM_PM = 1'b0; Hours = '0; Mins = '0;
        Secs = '0; MSecs = '0; Alarm = 1'b0;
        test_reset();
        test_clock_mode();
        test_stopwatch();
        test_midframe_change();
        test_alarm_blink();
        test_reset_mid_conversion();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
